key_sw_input_unit: RTL

//  Memory-mapped input device for KEY and SW; replaces the raw KEY/SW capture registers on the load path.

---
 rtl/key_sw_input_unit_pkg.sv | 25 ++
 rtl/key_sw_input_unit_io_debounce.sv | 51 +++++
 rtl/key_sw_input_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/key_sw_input_unit_pkg.sv
// rtl/key_sw_input_unit_pkg.sv - IO register map and address decode for the KEY/SW input unit
package key_sw_input_unit_pkg;

    localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
    localparam logic [31:0] ADDR_KEYEDGE = 32'hF000_0018;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_KEY   = 2'd1,
        SEL_SW    = 2'd2,
        SEL_KEDGE = 2'd3
    } io_sel_e;

    // Full 32-bit compare; partial matches must not alias onto these registers
    function automatic io_sel_e decode_io_addr(input logic [31:0] addr);
        io_sel_e sel;
        sel = SEL_NONE;
        if (addr == ADDR_KEY)          sel = SEL_KEY;
        else if (addr == ADDR_SW)      sel = SEL_SW;
        else if (addr == ADDR_KEYEDGE) sel = SEL_KEDGE;
        return sel;
    endfunction

endpackage

// File: rtl/key_sw_input_unit_io_debounce.sv
// rtl/key_sw_input_unit_io_debounce.sv - per-bit 2-flop synchroniser plus debounce counter
module io_debounce #(
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);
    // The increment that would reach DEBOUNCE_CYCLES instead commits the new level
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync2_q;
    logic                stable_q, stable_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // Counter runs only while the synchronised level disagrees with the accepted level
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
        end
    end

    // Synchroniser, counter and accepted level; reset forces the idle level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/key_sw_input_unit.sv
// rtl/key_sw_input_unit.sv - memory-mapped KEY/SW input device with sticky key press events
module key_sw_input_unit
    import key_sw_input_unit_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int KEY_WIDTH       = 4,
    parameter int SW_WIDTH        = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KEY_WIDTH-1:0] KEY,
    input  logic [SW_WIDTH-1:0]  SW,
    input  logic [DBITS-1:0]     dataAddr,
    input  logic                 isLoad,
    input  logic                 isStore,
    input  logic [DBITS-1:0]     wrData,
    output logic [DBITS-1:0]     rdData,
    output logic                 rdHit
);

    logic [KEY_WIDTH-1:0] key_stable;
    logic [SW_WIDTH-1:0]  sw_stable;
    logic [KEY_WIDTH-1:0] key_prev_q;
    logic [KEY_WIDTH-1:0] key_edge_q, key_edge_d;
    logic [KEY_WIDTH-1:0] key_fall, key_clr;
    io_sel_e              sel;
    logic                 unused_wr;

    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
        io_debounce #(
            .RESET_LEVEL     (1'b1),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (KEY[i]),
            .stable (key_stable[i])
        );
    end

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        io_debounce #(
            .RESET_LEVEL     (1'b0),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (SW[i]),
            .stable (sw_stable[i])
        );
    end

    assign unused_wr = ^wrData[DBITS-1:KEY_WIDTH];

    // Decode, press detection and write-1-to-clear; a new press beats a same-cycle clear
    always_comb begin
        sel        = decode_io_addr(32'(dataAddr));
        key_fall   = key_prev_q & ~key_stable;
        key_clr    = (isStore && sel == SEL_KEDGE) ? wrData[KEY_WIDTH-1:0] : '0;
        key_edge_d = (key_edge_q & ~key_clr) | key_fall;
    end

    // Read mux from registered state; a combined load+store behaves as a store only
    always_comb begin
        rdHit  = isLoad && !isStore && (sel != SEL_NONE);
        rdData = '0;
        if (rdHit) begin
            case (sel)
                SEL_KEY:   rdData[KEY_WIDTH-1:0] = key_stable;
                SEL_SW:    rdData[SW_WIDTH-1:0]  = sw_stable;
                SEL_KEDGE: rdData[KEY_WIDTH-1:0] = key_edge_q;
                default:   rdData = '0;
            endcase
        end
    end

    // Previous stable keys reset to released so leaving reset never looks like a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_prev_q <= '1;
            key_edge_q <= '0;
        end else begin
            key_prev_q <= key_stable;
            key_edge_q <= key_edge_d;
        end
    end

endmodule
